uart_rx_fifo: RTL and testbench

- Oversampled-counter UART receiver. It is the receive end of the 8N1 serial link driven by the board's UART transmitter.
- Deserialises bytes, validates start and stop bits, and buffers good bytes in a small show-ahead FIFO.
- Downstream logic (display, echo, debug LEDs) drains the FIFO through a valid/ready handshake.
- Sits between the board UART Rx pin and the byte consumers.

---
 rtl/uart_rx_fifo.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 oversampled UART receiver with a show-ahead byte FIFO.
// Bytes with a good stop bit are queued; consumers drain via valid/ready.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_serial,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [CNT_W-1:0] rx_count,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CLK_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CLK_W-1:0] HALF_T = CLK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CLK_W-1:0] FULL_T = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           state_q;
    logic [CLK_W-1:0] clk_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             sync1_q;
    logic             rxs_q;
    logic             frame_err_q;
    logic             overrun_q;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             valid_q;

    logic stop_done;
    logic full;
    logic pop;
    logic push;

    assign full      = (count_q == DEPTH_C);
    assign pop       = valid_q && rx_ready;
    assign stop_done = (state_q == S_STOP) && (clk_cnt_q == FULL_T);
    // A full FIFO still takes the byte when the head leaves the same cycle.
    assign push      = stop_done && rxs_q && (!full || pop);

    assign rx_data   = mem_q[rd_ptr_q];
    assign rx_valid  = valid_q;
    assign rx_count  = count_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

    // Two-flop synchroniser, reset to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx_serial;
            rxs_q   <= sync1_q;
        end
    end

    // Frame FSM: mid-bit sampling, stop-bit check, one-cycle status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    clk_cnt_q <= '0;
                    if (!rxs_q) state_q <= S_START;
                end
                S_START: begin
                    if (clk_cnt_q == HALF_T) begin
                        clk_cnt_q <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rxs_q ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CLK_W'(1);
                    end
                end
                S_DATA: begin
                    if (clk_cnt_q == FULL_T) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rxs_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_q <= S_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CLK_W'(1);
                    end
                end
                S_STOP: begin
                    if (clk_cnt_q == FULL_T) begin
                        clk_cnt_q <= '0;
                        if (rxs_q) begin
                            overrun_q <= full && !pop;
                            state_q   <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CLK_W'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    clk_cnt_q <= '0;
                    if (rxs_q) state_q <= S_IDLE;
                end
                default: begin
                    clk_cnt_q <= '0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    // Occupancy next-state; pop is gated by valid so it never underflows.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Show-ahead FIFO storage, wrapping pointers and registered valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of the UART receiver and its FIFO.
// Bytes are driven 8N1 at 16 clocks per bit; expectations are hand-derived.
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] rx_count;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_hi    = 0;
    int ov_hi    = 0;
    int both_hi  = 0;
    int fe0;
    int ov0;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4),
        .CNT_W       (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_serial(rx_serial),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_count (rx_count),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts high cycles of each status strobe.
    always @(negedge clk) begin
        if (frame_err) fe_hi++;
        if (overrun) ov_hi++;
        if (frame_err && overrun) both_hi++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rx_serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            tick(CPB);
        end
        rx_serial = stop;
        tick(CPB);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, rx_valid, 1);
        check({tag, "_data"}, rx_data, exp);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, rx_valid, 0);
        check({tag, "_data"}, rx_data, 8'h00);
        check({tag, "_count"}, rx_count, 0);
        check({tag, "_ferr"}, frame_err, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [7:0] part;
        rst       = 1'b1;
        rx_serial = 1'b1;
        rx_ready  = 1'b0;
        tick(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick(5);

        // Single byte; first capturing edge +154 edges gives rx_valid.
        fork
            send(8'hA5, 1'b1);
            begin
                tick(154);
                check("a5_lat_lo", rx_valid, 0);
                check("a5_busy", busy, 1);
                tick(1);
                check("a5_lat_hi", rx_valid, 1);
            end
        join
        check("a5_data", rx_data, 8'hA5);
        check("a5_count", rx_count, 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("a5_pop_valid", rx_valid, 0);
        check("a5_pop_count", rx_count, 0);

        // Fill, overrun on the fifth byte, then drain in order.
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h3C, 1'b1);
        send(8'hC3, 1'b1);
        check("fill_count", rx_count, 4);
        ov0 = ov_hi;
        send(8'h55, 1'b1);
        check("ovr_pulse", ov_hi - ov0, 1);
        check("ovr_count", rx_count, 4);
        pop_check("d0", 8'h00);
        pop_check("d1", 8'hFF);
        pop_check("d2", 8'h3C);
        pop_check("d3", 8'hC3);
        check("drain_empty", rx_valid, 0);

        // Short low glitch must not start a frame.
        fe0 = fe_hi;
        rx_serial = 1'b0;
        tick(5);
        check("glitch_busy", busy, 1);
        rx_serial = 1'b1;
        tick(30);
        check("glitch_idle", busy, 0);
        check("glitch_count", rx_count, 0);
        check("glitch_ferr", fe_hi - fe0, 0);

        // Bad stop bit, held break, then a good byte.
        fe0 = fe_hi;
        send(8'h81, 1'b0);
        tick(100);
        check("brk_busy", busy, 1);
        rx_serial = 1'b1;
        tick(20);
        check("brk_ferr", fe_hi - fe0, 1);
        check("brk_count", rx_count, 0);
        check("brk_idle", busy, 0);
        send(8'h42, 1'b1);
        check("b42_count", rx_count, 1);
        pop_check("b42", 8'h42);
        check("b42_ferr", fe_hi - fe0, 1);

        // Full FIFO with pop coinciding with the push of 0x99.
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        send(8'h44, 1'b1);
        check("full_count", rx_count, 4);
        ov0 = ov_hi;
        fork
            send(8'h99, 1'b1);
            begin
                tick(154);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        check("pp_ovr", ov_hi - ov0, 0);
        check("pp_count", rx_count, 4);
        pop_check("pp0", 8'h22);
        pop_check("pp1", 8'h33);
        pop_check("pp2", 8'h44);
        pop_check("pp3", 8'h99);
        check("pp_empty", rx_valid, 0);

        // Reset in data bit 4 abandons the frame.
        fe0  = fe_hi;
        ov0  = ov_hi;
        part = 8'hE6;
        rx_serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_serial = part[i];
            tick(CPB);
        end
        rx_serial = part[4];
        tick(CPB / 2);
        check("mid_busy", busy, 1);
        rst       = 1'b1;
        rx_serial = 1'b1;
        tick(2);
        check_idle_outputs("mid_rst");
        rst = 1'b0;
        tick(40);
        check_idle_outputs("post_rst");
        send(8'h17, 1'b1);
        check("b17_count", rx_count, 1);
        pop_check("b17", 8'h17);
        check("b17_ferr", fe_hi - fe0, 0);
        check("b17_ovr", ov_hi - ov0, 0);

        check("no_joint_pulse", both_hi, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
